// File: rtl/wired_lsu_sb_queue_pkg.sv
// wired0_defines: shared LSU store-buffer types.
//   sb_meta_t     : one store-buffer record (paddr, per-way dcache hit bits,
//                   byte strobes and store data).
//   dsram_snoop_t : DSRAM tag-SRAM write snoop (set address, per-way write
//                   enables and the tag being written).
// Default geometry constants are used as parameter defaults by the
// store-buffer queue and its slots.
package wired0_defines;

  localparam int SB_DEPTH   = 8;
  localparam int SB_WAYS    = 4;
  localparam int SB_SET_LSB = 4;
  localparam int SB_SET_MSB = 11;
  localparam int SB_TAG_W   = 31 - SB_SET_MSB;

  typedef struct packed {
    logic [31:0]         paddr;
    logic [SB_WAYS-1:0]  hit;
    logic [3:0]          strb;
    logic [31:0]         data;
  } sb_meta_t;

  typedef struct packed {
    logic [SB_TAG_W-1:0] p;
    logic                wp;
  } dsram_tag_t;

  typedef struct packed {
    logic [SB_SET_MSB:SB_SET_LSB] taddr;
    logic [SB_WAYS-1:0]           twe;
    dsram_tag_t                   t;
  } dsram_snoop_t;

endpackage

// File: rtl/wired_lsu_sb_slot.sv
// wired_lsu_sb_slot: one store-buffer entry.
// Holds valid + meta and keeps the per-way hit bits current by snooping
// tag-SRAM writes every cycle while valid.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears valid only)
//   wr, wr_meta   allocate this slot with wr_meta
//   clr           retire this slot
//   snoop         tag-SRAM write snoop
//   valid, meta   registered entry state
// Build option: WIRED_SB_SNOOP_BYPASS_EN applies the same-cycle snoop to
// wr_meta before it is stored.
module wired_lsu_sb_slot
  import wired0_defines::*;
#(
  parameter int WAYS    = SB_WAYS,
  parameter int SET_LSB = SB_SET_LSB,
  parameter int SET_MSB = SB_SET_MSB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  sb_meta_t     wr_meta,
  input  logic         clr,
  input  dsram_snoop_t snoop,
  output logic         valid,
  output sb_meta_t     meta
);

  function automatic sb_meta_t apply_snoop(sb_meta_t m, dsram_snoop_t s);
    sb_meta_t r;
    r = m;
    if (m.paddr[SET_MSB:SET_LSB] == s.taddr[SET_MSB:SET_LSB]) begin
      for (int w = 0; w < WAYS; w++) begin
        if (s.twe[w]) r.hit[w] = (s.t.p == m.paddr[31:SET_MSB+1]) && s.t.wp;
      end
    end
    return r;
  endfunction

  sb_meta_t wr_meta_eff;

`ifdef WIRED_SB_SNOOP_BYPASS_EN
  assign wr_meta_eff = apply_snoop(wr_meta, snoop);
`else
  assign wr_meta_eff = wr_meta;
`endif

  // When full, a push and a pop can target this slot together; the new
  // entry wins, so wr has priority over clr.
  always_ff @(posedge clk) begin
    if (rst)      valid <= 1'b0;
    else if (wr)  valid <= 1'b1;
    else if (clr) valid <= 1'b0;
  end

  // Meta storage is not reset; a snoop on a retiring entry is simply lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr)              meta <= wr_meta_eff;
      else if (valid && !clr) meta <= apply_snoop(meta, snoop);
    end
  end

endmodule

// File: rtl/wired_lsu_sb_queue.sv
// wired_lsu_sb_queue: DEPTH-entry circular store buffer between store
// commit and the dcache write port.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   push_i, meta_i     allocate tail entry (dropped when full without pop)
//   pop_i              retire head entry (ignored when empty)
//   snoop_i            tag-SRAM write snoop, applied to all valid entries
//   q_paddr_i          line-address query
//   q_mask_o, q_hit_o  valid entries on the queried line (by physical slot)
//   head_valid_o, head_meta_o  head entry
//   full_o, empty_o, count_o   occupancy (register-derived)
// Build option: WIRED_SB_SNOOP_BYPASS_EN (see wired_lsu_sb_slot).
module wired_lsu_sb_queue
  import wired0_defines::*;
#(
  parameter int DEPTH   = SB_DEPTH,
  parameter int WAYS    = SB_WAYS,
  parameter int SET_LSB = SB_SET_LSB,
  parameter int SET_MSB = SB_SET_MSB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  sb_meta_t                 meta_i,
  input  logic                     pop_i,
  input  dsram_snoop_t             snoop_i,
  input  logic [31:0]              q_paddr_i,
  output logic [DEPTH-1:0]         q_mask_o,
  output logic                     q_hit_o,
  output logic                     head_valid_o,
  output sb_meta_t                 head_meta_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    head, tail;
  logic [CNT_W-1:0] count;
  logic             push_acc, pop_acc;
  logic [DEPTH-1:0] slot_valid;
  sb_meta_t         slot_meta [DEPTH];

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_acc) tail <= tail + AW'(1);
      if (pop_acc)  head <= head + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    wired_lsu_sb_slot #(
      .WAYS    (WAYS),
      .SET_LSB (SET_LSB),
      .SET_MSB (SET_MSB)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr      (push_acc && (tail == AW'(i))),
      .wr_meta (meta_i),
      .clr     (pop_acc && (head == AW'(i))),
      .snoop   (snoop_i),
      .valid   (slot_valid[i]),
      .meta    (slot_meta[i])
    );

    assign q_mask_o[i] = slot_valid[i] &&
                         (slot_meta[i].paddr[31:SET_LSB] == q_paddr_i[31:SET_LSB]);
  end

  assign q_hit_o      = |q_mask_o;
  assign head_valid_o = slot_valid[head];
  assign head_meta_o  = slot_meta[head];

  // Line-offset bits of the query address do not take part in the compare.
  logic unused_q_offset;
  assign unused_q_offset = ^q_paddr_i[SET_LSB-1:0];

endmodule

// File: doc/wired_lsu_sb_queue.md
# wired_lsu_sb_queue

Parametrised LSU store buffer: a DEPTH-entry circular FIFO of `sb_meta_t` records between store commit and the dcache write port. All entries snoop DSRAM tag writes every cycle to keep per-way hit bits current. It adds a line-address query port for load forwarding/ordering and full/empty/count tracking. It replaces per-entry instantiation with one queue owning allocation order.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- WAYS, 4, dcache associativity; width of `hit` and `twe`
- SET_LSB, 4, lowest set-index bit of paddr
- SET_MSB, 11, highest set-index bit; tag is paddr[31:SET_MSB+1]
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- push_i  in  1  allocate tail entry with meta_i
- meta_i  in  sb_meta_t  new entry metadata
- pop_i  in  1  retire head entry
- snoop_i  in  dsram_snoop_t  tag-SRAM write snoop (taddr, twe[WAYS], t.p, t.wp)
- q_paddr_i  in  32  query address
- q_mask_o  out  DEPTH  valid entries with paddr[31:SET_LSB] == q_paddr_i[31:SET_LSB], indexed by physical slot
- q_hit_o  out  1  |q_mask_o
- head_valid_o  out  1  head entry valid
- head_meta_o  out  sb_meta_t  head entry metadata
- full_o, empty_o  out  1  occupancy flags
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: head/tail pointers of $clog2(DEPTH) bits (natural wrap), count, valid[DEPTH], meta[DEPTH].
- Push accepted iff push_i && (!full_o || pop accepted this cycle). If not accepted, it is dropped; the caller must gate on full_o, and the bench asserts this never happens.
- Pop accepted iff pop_i && !empty_o. Pop on empty is ignored and does not move the head.
- Accepted push writes meta[tail], sets valid[tail], and increments tail. Accepted pop clears valid[head] and increments head. count changes by +1, -1 or 0.
- Push and pop when full are both accepted: the head retires, the tail writes the freed order position, and count stays DEPTH.
- Push and pop when empty: push accepted, pop ignored, count becomes 1.
- Snoop runs every cycle on every valid entry.
  - An entry matches when entry paddr[SET_MSB:SET_LSB] == snoop_i.taddr[SET_MSB:SET_LSB].
  - For each way w with twe[w] set on a matching entry: hit[w] <= (t.p == paddr tag) && t.wp.
  - Ways without twe keep their hit bit.
- Invalid entries are not snooped; their meta is don't-care.
- Query is purely combinational over the registered valid/meta.
- head_meta_o = meta[head] (registered). head_valid_o = valid[head] = !empty_o.

## Timing
- Reset: head = tail = 0, count = 0, valid = 0, empty_o = 1, full_o = 0, head_valid_o = 0, q_mask_o = 0, q_hit_o = 0. head_meta_o is undefined. meta storage is not reset.
- Reset is synchronous and dominates push/pop/snoop in the same cycle. Reset mid-operation discards all entries.
- Pushed entry: visible on head_* and q_* the cycle after acceptance.
- Snoop update: visible one cycle after snoop_i is presented.
- Pop: the entry leaves head/query the next cycle.
- Snoop in the same cycle as a pop of that entry: the update is discarded with the entry.
- Snoop in the same cycle as a push: see Configuration.
- full_o, empty_o and count_o are registered-derived, with no combinational path from push_i/pop_i.

## Configuration
- WIRED_SB_SNOOP_BYPASS_EN defined: a pushed meta_i has the same-cycle snoop applied before storage (same match rule as resident entries). Same-cycle tag writes are never lost, and the caller needs no external snoop.
- Not defined: meta_i is stored verbatim. The caller must pre-apply the snoop to meta_i. The bench checks hit bits against the caller-supplied value.

## Structure
- Shared package (wired0_defines): `sb_meta_t` (paddr[31:0], hit[WAYS-1:0], plus existing strb/data fields) and `dsram_snoop_t`. Defaults come from package constants.
- Sub-module `wired_lsu_sb_slot` holds one entry: valid, meta, and snoop-update logic, with the bypass path under the macro. Generate DEPTH instances.
- Pointer/count logic and the query compare live in the top.

## Test plan
- Reset, then push 8 entries (DEPTH=8) at paddr 0x1000+16·i -> count_o=8 and full_o=1. A 9th push alone is flagged by the assertion; pop+push in the same cycle keeps count_o=8.
- Push A at 0x0000_2040 (hit=0000). Snoop taddr[11:4]=0x04, twe=0010, t.p=0x00002, t.wp=1 -> next cycle head hit=0010. Repeat with t.wp=0 -> hit=0000.
- Snoop with twe=0100 and a different tag on a same-set entry holding hit=0010 -> hit=0010 (way 1 untouched, way 2 cleared).
- Push and snoop (matching, twe=0001) in the same cycle -> with the macro, stored hit=0001; without it, hit=meta_i.hit.
- Fill 3, pop 2, push 7 (tail wraps) -> head order preserved. Query 0x1008 with an entry at 0x1000 -> q_hit_o=1 and the correct slot bit set.
- Assert rst with count=5 while push_i=1 -> next cycle empty_o=1, count_o=0, q_mask_o=0.
